// File: rtl/load_store_unit.sv
// load_store_unit: maps byte-addressed RISC-V loads/stores onto a word-only data memory,
// doing SB/SH as a read-modify-write through a MERGE cycle.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Mem_Addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data
);
  typedef enum logic {IDLE, MERGE} state_e;
  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [1:0]  lane;
  logic        idle, legal, misal, oor, flt, go, ld, sub, sw;
  logic [4:0]  sh;
  logic [31:0] mask, rd_sh, ext;
  always_comb begin
    lane    = addr[1:0];
    idle    = state_q == IDLE;
    legal   = req_we ? funct3 <= 3'd2 : (funct3 != 3'd3 && funct3 <= 3'd5);
    misal   = (funct3[1:0] == 2'd1 && addr[0]) || (funct3[1:0] == 2'd2 && lane != 2'd0);
    oor     = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
    flt     = idle && req_valid && (!legal || misal || oor);
    go      = idle && req_valid && !flt;
    ld      = go && !req_we;
    sub     = go && req_we && funct3[1:0] != 2'd2;
    sw      = go && req_we && funct3[1:0] == 2'd2;
    // halfwords move in 16-bit steps (lane 0 or 2), bytes in 8-bit steps
    sh      = funct3[0] ? {lane[1], 4'b0000} : {lane, 3'b000};
    mask    = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    rd_sh   = rd_data >> sh;
    ext     = funct3[1] ? rd_data :
              funct3[0] ? {{16{~funct3[2] & rd_sh[15]}}, rd_sh[15:0]} :
                          {{24{~funct3[2] & rd_sh[7]}}, rd_sh[7:0]};
    state_d = sub ? MERGE : IDLE;
    merge_d = sub ? (rd_data & ~mask) | ((store_data << sh) & mask) : merge_q;
  end
  assign Mem_Addr  = {2'b00, addr[31:2]};
  assign MemRead   = !reset && (ld || sub);
  assign MemWrite  = !reset && (sw || !idle);
  assign stall     = !reset && sub;
  assign fault     = !reset && flt;
  assign load_data = (!reset && ld) ? ext : 32'h0;
  assign wr_data   = reset ? 32'h0 : idle ? store_data : merge_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the word-addressed data memory. It converts byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses. It extracts and sign- or zero-extends load data, and flags misaligned, out-of-range or illegal accesses. The data memory has no byte enables, so SB and SH are done as a two-cycle read-modify-write, and the unit stalls the core for one cycle while it runs.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words in data memory; word index ≥ DEPTH_WORDS is a fault.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a memory instruction this cycle.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V funct3 of the instruction (size/sign).
- addr  in  32  byte address.
- store_data  in  32  rs2 value; low byte/half used for SB/SH.
- load_data  out  32  extended load result; 0 when no valid load.
- stall  out  1  core must hold its request and PC this cycle.
- fault  out  1  current request is misaligned, out of range or has illegal funct3; no memory access is made.
- MemRead  out  1  to data memory: read strobe.
- MemWrite  out  1  to data memory: write strobe (memory writes on rising edge).
- Mem_Addr  out  32  word index = {2'b00, addr[31:2]}.
- wr_data  out  32  word to write.
- rd_data  in  32  combinational read word from data memory.

## Operation
- Lane = addr[1:0], little-endian: byte k occupies bits [8k+7:8k].
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 sets fault.
- Misaligned: a halfword with addr[0]=1, or a word with addr[1:0]≠0. Sets fault.
- Out of range: addr[31:2] ≥ DEPTH_WORDS. Sets fault.
- When fault is set: MemRead=MemWrite=0, load_data=0, stall=0. The request is dropped.
- Load (IDLE, valid, no fault): MemRead=1 and load_data is produced combinationally in the same cycle.
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
  - LH uses lane 0 or 2.
- SW (IDLE, valid, no fault): MemWrite=1 and wr_data=store_data, in one cycle, with no stall.
- SB/SH use a two-state FSM: IDLE and MERGE.
  - IDLE, sub-word store, no fault: MemRead=1 and stall=1. On the clock edge, merge_reg captures rd_data with the selected lane replaced by store_data[7:0] (SB) or store_data[15:0] (SH), and the FSM goes to MERGE.
  - MERGE: MemWrite=1, wr_data=merge_reg, Mem_Addr from the held addr, stall=0, MemRead=0. The inputs are ignored (they are the same held instruction). On the clock edge the FSM returns to IDLE.
- In IDLE with req_valid=0, every strobe is 0, stall=0 and load_data=0.
- wr_data is store_data in IDLE and merge_reg in MERGE.
- fault is computed only in IDLE. It is 0 in MERGE.

## Timing
- Reset (asynchronous): state=IDLE, merge_reg=0.
  - While reset is high, MemRead, MemWrite, stall and fault are forced to 0, load_data=0 and wr_data=0.
  - Mem_Addr still follows addr.
- Load latency is 0 cycles (combinational through memory). SW takes 1 cycle. SB/SH take 2 cycles: a read cycle with stall=1, then a write cycle with stall=0.
- The core advances on the first edge where stall=0. For a sub-word store that is the MERGE-cycle edge.
- Reset asserted in MERGE: the FSM returns to IDLE immediately and the pending write is aborted. Memory must be unmodified.
- A memory write committed at the end of MERGE is visible to a load issued in the very next cycle (the read is combinational from updated memory).
- A back-to-back SB after SB re-enters the read cycle from IDLE. There is no pipelining across stores.

## Test plan
- Memory word 5 = 0x8899AABB. LB, LBU, LH and LHU at addr 0x14 and 0x17 give:
  - LB @0x14 → 0xFFFFFFBB; LBU @0x14 → 0x000000BB.
  - LH @0x14 → 0xFFFFAABB; LHU @0x14 → 0x0000AABB.
  - LB @0x17 → 0xFFFFFF88.
- Word 3 = 0x11223344. SB 0xA5 at addr 0x0E:
  - Cycle 1: stall=1, MemRead=1.
  - Cycle 2: MemWrite=1, wr_data=0x11A53344, stall=0.
  - A following LW @0x0C → 0x11A53344.
- SH 0xBEEF at addr 0x12 over 0x00000000 → 0xBEEF0000. SW 0xDEADBEEF at 0x20 → one cycle, stall never 1.
- Misaligned LW @0x02, misaligned SH @0x01, funct3=011 load, and LW @0x100 with DEPTH_WORDS=64 → fault=1, MemRead=MemWrite=0, load_data=0, memory unchanged.
- SB issued, then reset asserted during the MERGE cycle → stall and MemWrite drop immediately, state returns to IDLE, and the target word keeps its old value.
- Random mix of 1000 legal and illegal loads and stores against a byte-array reference model → load_data and final memory contents match exactly.
